alu_pipe: RTL and testbench

//  Parametrised, lane-vectorised integer ALU with valid/ready handshakes on both sides.

---
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake and result bundle for alu_pipe: operand side (in_*), result side (out_*, y_*, flags).
interface alu_pipe_if #(
   parameter int unsigned LANE_W = 16,
   parameter int unsigned LANES  = 2
);
   localparam int unsigned W = LANE_W * LANES;

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             vec;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     y_lo;
   logic [W-1:0]     y_hi;
   logic [LANES-1:0] cout;
   logic             dz;
   logic             busy;

   modport master (
      output in_valid, op, vec, a, b, out_ready,
      input  in_ready, out_valid, y_lo, y_hi, cout, dz, busy
   );

   modport slave (
      input  in_valid, op, vec, a, b, out_ready,
      output in_ready, out_valid, y_lo, y_hi, cout, dz, busy
   );
endinterface

// File: rtl/alu_pipe.sv
// Lane-vectorised integer ALU with one op in flight: single-cycle logic/arith ops,
// iterative shift-add MULT and restoring DIV, registered results behind valid/ready.
module alu_pipe #(
   parameter int unsigned LANE_W = 16,
   parameter int unsigned LANES  = 2
) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);
   localparam int unsigned W  = LANE_W * LANES;
   localparam int unsigned CW = $clog2(W + 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_MULT = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b101;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_COPY = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic             accept_c, iter_in_c, last_c;
   logic [CW-1:0]    n_c;

   logic             vec_q, div_q, dzp_q;
   logic [CW-1:0]    cnt_q;
   logic [W-1:0]     hi_q, lo_q, opnd_q;
   logic [W-1:0]     y_lo_q, y_hi_q;
   logic [LANES-1:0] cout_q;
   logic             dz_q, out_valid_q, busy_q;

   logic [W-1:0]      simple_lo, simple_hi;
   logic [LANES-1:0]  simple_cout;
   logic              dz_in;
   logic [W:0]        s_sum, s_diff;
   logic [LANE_W:0]   l_sum [LANES];
   logic [LANE_W:0]   l_diff[LANES];
   logic [LANES-1:0]  l_bzero;

   logic [W:0]        ms_sum, ds_rem;
   logic [W-1:0]      ds_diff;
   logic              ds_ge;
   logic [LANE_W:0]   mv_sum[LANES];
   logic [LANE_W:0]   dv_rem[LANES];
   logic [LANE_W-1:0] dv_diff[LANES];
   logic [LANES-1:0]  dv_ge;
   logic [W-1:0]      step_hi, step_lo;

   assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
   assign bus.out_valid = out_valid_q;
   assign bus.y_lo      = y_lo_q;
   assign bus.y_hi      = y_hi_q;
   assign bus.cout      = cout_q;
   assign bus.dz        = dz_q;
   assign bus.busy      = busy_q;

   assign accept_c  = bus.in_valid & bus.in_ready;
   assign iter_in_c = (bus.op == OP_MULT) | (bus.op == OP_DIV);
   assign n_c       = vec_q ? CW'(LANE_W) : CW'(W);
   assign last_c    = (state_q == BUSY) && ((cnt_q + CW'(1)) == n_c);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept_c) state_d = iter_in_c ? BUSY : DONE;
         BUSY: if (last_c) state_d = DONE;
         DONE: begin
            if (accept_c)           state_d = iter_in_c ? BUSY : DONE;
            else if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Single-cycle ops, evaluated straight from the offered operands
   always_comb begin
      simple_lo   = '0;
      simple_hi   = '0;
      simple_cout = '0;
      s_sum       = {1'b0, bus.a} + {1'b0, bus.b};
      s_diff      = {1'b0, bus.a} - {1'b0, bus.b};
      for (int l = 0; l < LANES; l++) begin
         l_sum[l]   = {1'b0, bus.a[l*LANE_W +: LANE_W]} + {1'b0, bus.b[l*LANE_W +: LANE_W]};
         l_diff[l]  = {1'b0, bus.a[l*LANE_W +: LANE_W]} - {1'b0, bus.b[l*LANE_W +: LANE_W]};
         l_bzero[l] = (bus.b[l*LANE_W +: LANE_W] == '0);
      end
      case (bus.op)
         OP_ADD: begin
            if (bus.vec) begin
               for (int l = 0; l < LANES; l++) begin
                  simple_lo[l*LANE_W +: LANE_W] = l_sum[l][LANE_W-1:0];
                  simple_cout[l]                = l_sum[l][LANE_W];
               end
            end else begin
               simple_lo      = s_sum[W-1:0];
               simple_cout[0] = s_sum[W];
            end
         end
         OP_SUB: begin
            if (bus.vec) begin
               for (int l = 0; l < LANES; l++) begin
                  simple_lo[l*LANE_W +: LANE_W] = l_diff[l][LANE_W-1:0];
                  simple_cout[l]                = l_diff[l][LANE_W];
               end
            end else begin
               simple_lo      = s_diff[W-1:0];
               simple_cout[0] = s_diff[W];
            end
         end
         OP_AND:  simple_lo = bus.a & bus.b;
         OP_OR:   simple_lo = bus.a | bus.b;
         OP_XOR:  simple_lo = bus.a ^ bus.b;
         OP_COPY: begin
            simple_lo = bus.a;
            simple_hi = bus.b;
         end
         default: ;
      endcase
      dz_in = (bus.op == OP_DIV) & (bus.vec ? (|l_bzero) : (bus.b == '0));
   end

   // One MULT/DIV iteration: MULT shifts {hi,lo} right, DIV shifts left into the remainder
   always_comb begin
      step_hi = '0;
      step_lo = '0;
      ms_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      ds_rem  = {hi_q, lo_q[W-1]};
      ds_diff = ds_rem[W-1:0] - opnd_q;
      ds_ge   = (ds_rem >= {1'b0, opnd_q});
      for (int l = 0; l < LANES; l++) begin
         mv_sum[l]  = {1'b0, hi_q[l*LANE_W +: LANE_W]}
                    + (lo_q[l*LANE_W] ? {1'b0, opnd_q[l*LANE_W +: LANE_W]} : '0);
         dv_rem[l]  = {hi_q[l*LANE_W +: LANE_W], lo_q[l*LANE_W + LANE_W - 1]};
         dv_diff[l] = dv_rem[l][LANE_W-1:0] - opnd_q[l*LANE_W +: LANE_W];
         dv_ge[l]   = (dv_rem[l] >= {1'b0, opnd_q[l*LANE_W +: LANE_W]});
      end
      if (!div_q && !vec_q) begin
         step_hi = ms_sum[W:1];
         step_lo = {ms_sum[0], lo_q[W-1:1]};
      end else if (!div_q) begin
         for (int l = 0; l < LANES; l++) begin
            step_hi[l*LANE_W +: LANE_W] = mv_sum[l][LANE_W:1];
            step_lo[l*LANE_W +: LANE_W] = {mv_sum[l][0], lo_q[l*LANE_W + 1 +: LANE_W - 1]};
         end
      end else if (!vec_q) begin
         step_hi = ds_ge ? ds_diff : ds_rem[W-1:0];
         step_lo = {lo_q[W-2:0], ds_ge};
      end else begin
         for (int l = 0; l < LANES; l++) begin
            step_hi[l*LANE_W +: LANE_W] = dv_ge[l] ? dv_diff[l] : dv_rem[l][LANE_W-1:0];
            step_lo[l*LANE_W +: LANE_W] = {lo_q[l*LANE_W +: LANE_W - 1], dv_ge[l]};
         end
      end
   end

   // Operand capture, iteration registers and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q       <= 1'b0;
         div_q       <= 1'b0;
         dzp_q       <= 1'b0;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         y_lo_q      <= '0;
         y_hi_q      <= '0;
         cout_q      <= '0;
         dz_q        <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d == BUSY);
         if (accept_c) begin
            vec_q  <= bus.vec;
            div_q  <= (bus.op == OP_DIV);
            dzp_q  <= dz_in;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= bus.a;
            opnd_q <= bus.b;
            if (!iter_in_c) begin
               y_lo_q <= simple_lo;
               y_hi_q <= simple_hi;
               cout_q <= simple_cout;
               dz_q   <= 1'b0;
            end
         end else if (state_q == BUSY) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CW'(1);
            if (last_c) begin
               y_lo_q <= step_lo;
               y_hi_q <= step_hi;
               cout_q <= '0;
               dz_q   <= dzp_q;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against a lane-arithmetic reference model.
module tb_alu_pipe;
   localparam int unsigned LANE_W = 16;
   localparam int unsigned LANES  = 2;
   localparam int unsigned W      = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_err = 0;
   int   n_chk = 0;

   alu_pipe_if #(.LANE_W(LANE_W), .LANES(LANES)) bus();
   alu_pipe #(.LANE_W(LANE_W), .LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic per lane (vec) or on the whole word (scalar)
   task automatic model(input logic [2:0] op, input logic v, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo, output logic [31:0] hi, output logic [1:0] c,
                        output logic d);
      int nl, lw;
      longint unsigned mask, av, bv, r, plo, phi;
      nl = v ? 2 : 1;
      lw = v ? 16 : 32;
      mask = (64'd1 << lw) - 64'd1;
      lo = '0; hi = '0; c = '0; d = 1'b0;
      case (op)
         3'b010: lo = a & b;
         3'b011: lo = a | b;
         3'b110: lo = a ^ b;
         3'b111: begin lo = a; hi = b; end
         default: begin
            for (int l = 0; l < nl; l++) begin
               av = (64'(a) >> (l * lw)) & mask;
               bv = (64'(b) >> (l * lw)) & mask;
               plo = 0; phi = 0;
               case (op)
                  3'b000: begin r = av + bv; plo = r & mask; c[l] = (r > mask); end
                  3'b100: begin plo = (av - bv) & mask; c[l] = (av < bv); end
                  3'b001: begin r = av * bv; plo = r & mask; phi = r >> lw; end
                  default: begin
                     if (bv == 0) begin plo = mask; phi = av; d = 1'b1; end
                     else begin plo = av / bv; phi = av % bv; end
                  end
               endcase
               lo = lo | 32'(plo << (l * lw));
               hi = hi | 32'(phi << (l * lw));
            end
         end
      endcase
   endtask

   // Offer one op with out_ready=1, check latency, busy time and the result
   task automatic do_op(input string tag, input logic [2:0] op, input logic v,
                        input logic [31:0] a, input logic [31:0] b);
      logic [31:0] elo, ehi;
      logic [1:0]  ec;
      logic        ed;
      int          lat, nbusy, guard, n;
      model(op, v, a, b, elo, ehi, ec, ed);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.op = op; bus.vec = v; bus.a = a; bus.b = b;
      @(negedge clk);
      guard = 0;
      while (!bus.in_ready && guard < 100) begin @(negedge clk); guard++; end
      if (guard >= 100) begin
         chk({tag, "_accept_timeout"}, 64'(0), 64'(1));
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1; nbusy = 0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.busy) nbusy++;
         @(posedge clk); #1; lat++;
      end
      n = (op == 3'b001 || op == 3'b101) ? (v ? 16 : 32) : 0;
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
      chk({tag, "_lat"},   64'(lat),   64'(n + 1));
      chk({tag, "_busy"},  64'(nbusy), 64'(n));
      chk({tag, "_ylo"},   64'(bus.y_lo), 64'(elo));
      chk({tag, "_yhi"},   64'(bus.y_hi), 64'(ehi));
      chk({tag, "_cout"},  64'(bus.cout), 64'(ec));
      chk({tag, "_dz"},    64'(bus.dz),   64'(ed));
   endtask

   initial begin
      logic [31:0] elo, ehi, exp_lo[4], hold_lo, hold_hi;
      logic [1:0]  ec, hold_c;
      logic        ed;
      logic [2:0]  rop;
      logic        rv;
      logic [31:0] ra, rb;

      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.vec = 1'b0;
      bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_busy",      64'(bus.busy),      64'(0));
      chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
      chk("rst_ylo",       64'(bus.y_lo),      64'(0));
      chk("rst_yhi",       64'(bus.y_hi),      64'(0));

      do_op("add_1_2",   3'b000, 1'b0, 32'd1, 32'd2);
      do_op("sub_1_3",   3'b100, 1'b0, 32'd1, 32'd3);
      do_op("vadd",      3'b000, 1'b1, 32'h0001FFFF, 32'h00010001);
      do_op("vsub",      3'b100, 1'b1, 32'h00030002, 32'h00010003);
      do_op("mult",      3'b001, 1'b0, 32'hFFFFFFFF, 32'd2);
      do_op("vmult",     3'b001, 1'b1, 32'h00030100, 32'h00040100);
      do_op("div_7_2",   3'b101, 1'b0, 32'd7, 32'd2);
      do_op("div_5_0",   3'b101, 1'b0, 32'd5, 32'd0);
      do_op("vdiv_z",    3'b101, 1'b1, 32'h00090064, 32'h00000007);
      do_op("copy",      3'b111, 1'b1, 32'h12345678, 32'h9ABCDEF0);

      // Back-to-back simple ops, one result per cycle
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.op = 3'b000; bus.vec = 1'b0;
         bus.a = $urandom; bus.b = $urandom;
         model(3'b000, 1'b0, bus.a, bus.b, exp_lo[i], ehi, ec, ed);
         @(posedge clk); #1;
         chk("b2b_valid", 64'(bus.out_valid), 64'(1));
         chk("b2b_ylo",   64'(bus.y_lo), 64'(exp_lo[i]));
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_drain", 64'(bus.out_valid), 64'(0));

      // Backpressure: result must hold while the operand bus keeps changing
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.op = 3'b000; bus.vec = 1'b1;
      bus.a = $urandom; bus.b = $urandom;
      model(3'b000, 1'b1, bus.a, bus.b, hold_lo, hold_hi, hold_c, ed);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp_valid", 64'(bus.out_valid), 64'(1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.a = $urandom; bus.b = $urandom;
         @(posedge clk); #1;
         chk("bp_hold_valid", 64'(bus.out_valid), 64'(1));
         chk("bp_hold_ylo",   64'(bus.y_lo), 64'(hold_lo));
         chk("bp_hold_yhi",   64'(bus.y_hi), 64'(hold_hi));
         chk("bp_hold_cout",  64'(bus.cout), 64'(hold_c));
         chk("bp_in_ready",   64'(bus.in_ready), 64'(0));
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 64'(bus.out_valid), 64'(0));

      // Randomised ops, with occasional zero divisor lanes
      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         rv  = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 3) == 0) rb[15:0] = '0;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         do_op($sformatf("rnd%0d_op%0d_v%0d", i, rop, rv), rop, rv, ra, rb);
      end

      // Reset in the middle of a DIV aborts it
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.op = 3'b101; bus.vec = 1'b0;
      bus.a = 32'hDEADBEEF; bus.b = 32'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_valid", 64'(bus.out_valid), 64'(0));
      chk("rstmid_busy",  64'(bus.busy), 64'(0));
      chk("rstmid_ylo",   64'(bus.y_lo), 64'(0));
      chk("rstmid_yhi",   64'(bus.y_hi), 64'(0));
      chk("rstmid_cout",  64'(bus.cout), 64'(0));
      chk("rstmid_dz",    64'(bus.dz), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstmid_in_ready", 64'(bus.in_ready), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid_no_result", 64'(bus.out_valid), 64'(0));
      do_op("post_rst_add", 3'b000, 1'b0, 32'd1, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
